sram_controller_mc: RTL

- Next-generation SRAM controller for the forward-transform SoC.
- Serves AHB single-word reads and writes, and arbitrates NUM_CH accelerator write channels onto one shared SRAM write port.
- Channels use a valid/ready handshake and are arbitrated round-robin; AHB writes take priority.
- Sits between the AHB decoder/mux and the dual-port SRAM model; replaces the single-channel controller.

---
 rtl/sram_ctrl_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 47 ++++
 rtl/sram_controller_mc.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared types and constants for the SRAM controller
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_DATA
    } ahb_state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam int NUM_CH_MAX      = 8;
    localparam int SRAM_RD_LAT_MAX = 4;
    localparam int LAT_CNT_W       = $clog2(SRAM_RD_LAT_MAX);

    // NONSEQ and SEQ both carry a real transfer; IDLE and BUSY do not.
    function automatic logic htrans_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter; search starts one past the last granted requester
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] next_ptr;
    logic          found;

    // Two passes: requesters above the pointer first, then wrap to the rest.
    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        found    = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!found && req[j] && (j > int'(ptr))) begin
                grant[j] = 1'b1;
                next_ptr = PW'(j);
                found    = 1'b1;
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!found && req[j] && (j <= int'(ptr))) begin
                grant[j] = 1'b1;
                next_ptr = PW'(j);
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= PW'(N - 1);
        end else if (advance) begin
            ptr <= next_ptr;
        end
    end

endmodule

// File: rtl/sram_controller_mc.sv
// rtl/sram_controller_mc.sv - AHB slave plus multi-channel SRAM write arbiter; SRAM_CTRL_STALL_CNT_EN adds a stall counter
module sram_controller_mc
    import sram_ctrl_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 32,
    parameter int SRAM_RD_LAT = 1
) (
    input  logic                     in_HCLK,
    input  logic                     in_HRESET,
    input  logic                     in_HSEL,
    input  logic                     in_HREADY,
    input  logic [1:0]               in_HTRANS,
    input  logic                     in_HWRITE,
    input  logic [31:0]              in_HADDR,
    input  logic [31:0]              in_HWDATA,
    output logic                     out_HREADY,
    output logic [31:0]              out_HRDATA,
    input  logic [NUM_CH-1:0]        in_ch_valid,
    input  logic [NUM_CH*ADDR_W-1:0] in_ch_addr,
    input  logic [NUM_CH*DATA_W-1:0] in_ch_data,
    output logic [NUM_CH-1:0]        out_ch_ready,
    output logic                     out_write_en,
    output logic [ADDR_W-1:0]        out_sram_write_addr,
    output logic [DATA_W-1:0]        out_sram_write_data,
    output logic                     out_read_en,
    output logic [ADDR_W-1:0]        out_sram_read_addr,
    input  logic [DATA_W-1:0]        in_sram_read_data,
    output logic [31:0]              out_stall_cnt
);

    ahb_state_e           state;
    logic [ADDR_W-1:0]    wr_addr_q;
    logic [LAT_CNT_W-1:0] lat_cnt;
    logic                 fwd_q;
    logic [DATA_W-1:0]    fwd_data_q;
    logic                 active;
    logic                 accept;
    logic                 wr_phase;
    logic                 ch_xfer;
    logic [NUM_CH-1:0]    grant;
    logic [ADDR_W-1:0]    ch_addr_sel;
    logic [DATA_W-1:0]    ch_data_sel;
    logic [ADDR_W-1:0]    haddr_word;
    logic                 unused_haddr;

    // Upper address bits alias; byte-lane bits are meaningless for word access.
    assign haddr_word   = in_HADDR[ADDR_W+1:2];
    assign unused_haddr = ^{in_HADDR[31:ADDR_W+2], in_HADDR[1:0]};

    assign wr_phase = (state == WR_DATA);
    assign accept   = in_HSEL & in_HREADY & htrans_active(in_HTRANS) &
                      ((state == IDLE) | wr_phase);

    // The AHB write data phase owns the write port, so every channel is held off.
    assign out_ch_ready = grant & {NUM_CH{active & ~wr_phase}};
    assign ch_xfer      = |(in_ch_valid & out_ch_ready);

    rr_arbiter #(.N(NUM_CH)) u_arb (
        .clk     (in_HCLK),
        .rst_n   (in_HRESET),
        .req     (in_ch_valid),
        .advance (ch_xfer),
        .grant   (grant)
    );

    always_comb begin
        ch_addr_sel = '0;
        ch_data_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                ch_addr_sel = in_ch_addr[i*ADDR_W +: ADDR_W];
                ch_data_sel = in_ch_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge in_HCLK or negedge in_HRESET) begin
        if (!in_HRESET) begin
            state               <= IDLE;
            active              <= 1'b0;
            wr_addr_q           <= '0;
            lat_cnt             <= '0;
            fwd_q               <= 1'b0;
            fwd_data_q          <= '0;
            out_HREADY          <= 1'b1;
            out_HRDATA          <= '0;
            out_read_en         <= 1'b0;
            out_sram_read_addr  <= '0;
            out_write_en        <= 1'b0;
            out_sram_write_addr <= '0;
            out_sram_write_data <= '0;
        end else begin
            active      <= 1'b1;
            out_read_en <= 1'b0;
            case (state)
                IDLE, WR_DATA: begin
                    if (accept && in_HWRITE) begin
                        wr_addr_q <= haddr_word;
                        state     <= WR_DATA;
                    end else if (accept) begin
                        out_read_en        <= 1'b1;
                        out_sram_read_addr <= haddr_word;
                        out_HREADY         <= 1'b0;
                        state              <= RD_ISSUE;
                    end else begin
                        state <= IDLE;
                    end
                end
                RD_ISSUE: begin
                    // Same-cycle write to the read address: SRAM returns stale data.
                    fwd_q      <= out_write_en && (out_sram_write_addr == out_sram_read_addr);
                    fwd_data_q <= out_sram_write_data;
                    lat_cnt    <= '0;
                    state      <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (lat_cnt == LAT_CNT_W'(SRAM_RD_LAT - 1)) begin
                        out_HRDATA <= fwd_q ? 32'(fwd_data_q) : 32'(in_sram_read_data);
                        out_HREADY <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (wr_phase) begin
                out_write_en        <= 1'b1;
                out_sram_write_addr <= wr_addr_q;
                out_sram_write_data <= DATA_W'(in_HWDATA);
            end else if (ch_xfer) begin
                out_write_en        <= 1'b1;
                out_sram_write_addr <= ch_addr_sel;
                out_sram_write_data <= ch_data_sel;
            end else begin
                out_write_en <= 1'b0;
            end
        end
    end

`ifdef SRAM_CTRL_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge in_HCLK or negedge in_HRESET) begin
        if (!in_HRESET) begin
            stall_q <= '0;
        end else if ((|(in_ch_valid & ~out_ch_ready)) && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign out_stall_cnt = stall_q;
`else
    assign out_stall_cnt = '0;
`endif

endmodule
